// File: rtl/rv32_pkg.sv
// rv32: shared integer-core base types.
//   gpr_addr_t : 5-bit general purpose register index (x0..x31)
//   word       : 32-bit data word
//   REG_COUNT  : number of architectural integer registers
package rv32;

    localparam int REG_COUNT = 32;

    typedef logic [4:0]  gpr_addr_t;
    typedef logic [31:0] word;

endpackage

// File: rtl/saratoga_pkg.sv
// saratoga: write-back path types shared by regfile_wb_ctrl and its
// sub-modules.
//   wb_req_t              : one write-back request (valid, addr, data)
//   WB_STARVE_MAX_DEFAULT : default long-latency starvation limit
//   wb_req_active()       : request that actually needs the write port
package saratoga;

    typedef struct packed {
        logic           valid;
        rv32::gpr_addr_t addr;
        rv32::word      data;
    } wb_req_t;

    localparam int unsigned WB_STARVE_MAX_DEFAULT = 4;

    // x0 requests are accepted but never consume the port.
    function automatic logic wb_req_active(input wb_req_t req);
        return req.valid && (req.addr != '0);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register busy bits for outstanding long-latency
// destinations.
//   clk, rst            : clock, synchronous active-high reset
//   set_en, set_addr    : mark a register busy (long-latency issue)
//   clr_en, clr_addr    : mark a register free (long-latency commit)
//   rs1_addr, rs2_addr  : decode source lookups
//   issue_addr          : decode destination lookup
//   rs_busy             : rs1 or rs2 is busy
//   issue_busy          : issue_addr is busy
// Lookups read only the registered bits, so a commit in cycle N is
// visible as "free" from cycle N+1.
module wb_scoreboard
    import saratoga::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  rv32::gpr_addr_t set_addr,
    input  logic            clr_en,
    input  rv32::gpr_addr_t clr_addr,
    input  rv32::gpr_addr_t rs1_addr,
    input  rv32::gpr_addr_t rs2_addr,
    input  rv32::gpr_addr_t issue_addr,
    output logic            rs_busy,
    output logic            issue_busy
);

    // x0 has no storage: it is tied to 0 in the lookup vector.
    logic [rv32::REG_COUNT-1:1] busy;
    logic [rv32::REG_COUNT-1:0] busy_vec;

    assign busy_vec = {busy, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            // Clear first, then set: a same-cycle set on the same register
            // wins because the newly issued op is still outstanding.
            if (clr_en && (clr_addr != '0)) begin
                busy[clr_addr] <= 1'b0;
            end
            if (set_en && (set_addr != '0)) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rs_busy    = busy_vec[rs1_addr] || busy_vec[rs2_addr];
        issue_busy = busy_vec[issue_addr];
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: shares the single regfile write port between the
// execute stage and the long-latency unit, and tracks busy destinations
// for decode hazard detection.
//   STARVE_MAX                  : max consecutive lost long-latency cycles (1..15)
//   clk, rst                    : clock, synchronous active-high reset
//   ex_valid/ex_ready/ex_addr/ex_data : execute write-back request
//   ll_valid/ll_ready/ll_addr/ll_data : long-latency write-back request
//   issue_en, issue_addr        : long-latency dispatch, marks dest busy
//   issue_hazard                : issue_addr already busy (WAW)
//   rs1_addr, rs2_addr          : decode sources
//   rs_hazard                   : a source is busy (RAW)
//   dest_en/dest_addr/dest_data : regfile write port
// Optional feature macro: WB_STARVE_GUARD_EN compiles in the starvation
// counter that forces a long-latency grant after STARVE_MAX lost cycles;
// without it execute has strict priority.
//
// Handshake: a transfer occurs in a cycle where valid && ready. Requesters
// hold valid/addr/data stable until accepted. ready is asserted only for a
// valid request that is accepted this cycle and never depends on that
// requester's data. x0 requests are always accepted and never write.
module regfile_wb_ctrl
    import saratoga::*;
#(
    parameter int unsigned STARVE_MAX = WB_STARVE_MAX_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  rv32::gpr_addr_t ex_addr,
    input  rv32::word       ex_data,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  rv32::gpr_addr_t ll_addr,
    input  rv32::word       ll_data,
    input  logic            issue_en,
    input  rv32::gpr_addr_t issue_addr,
    output logic            issue_hazard,
    input  rv32::gpr_addr_t rs1_addr,
    input  rv32::gpr_addr_t rs2_addr,
    output logic            rs_hazard,
    output logic            dest_en,
    output rv32::gpr_addr_t dest_addr,
    output rv32::word       dest_data
);

    wb_req_t ex_req;
    wb_req_t ll_req;
    logic    ex_act;
    logic    ll_act;
    logic    force_ll;
    logic    ll_win;
    logic    rs_busy;
    logic    issue_busy;

    always_comb begin
        ex_req.valid = ex_valid;
        ex_req.addr  = ex_addr;
        ex_req.data  = ex_data;
        ll_req.valid = ll_valid;
        ll_req.addr  = ll_addr;
        ll_req.data  = ll_data;
    end

`ifdef WB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    // Counts consecutive cycles a valid long-latency request was refused.
    always_ff @(posedge clk) begin
        if (rst || !ll_valid || ll_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_ll = (starve_cnt >= STARVE_LIM);
`else
    assign force_ll = 1'b0;
`endif

    always_comb begin
        ex_act    = wb_req_active(ex_req);
        ll_act    = wb_req_active(ll_req);
        ll_win    = ll_act && (!ex_act || force_ll);
        ex_ready  = 1'b0;
        ll_ready  = 1'b0;
        dest_en   = 1'b0;
        dest_addr = '0;
        dest_data = '0;
        if (!rst) begin
            ex_ready = ex_valid && !(ex_act && ll_win);
            ll_ready = ll_valid && (!ll_act || ll_win);
            if (ll_win) begin
                dest_en   = 1'b1;
                dest_addr = ll_req.addr;
                dest_data = ll_req.data;
            end else if (ex_act) begin
                dest_en   = 1'b1;
                dest_addr = ex_req.addr;
                dest_data = ex_req.data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (issue_en),
        .set_addr   (issue_addr),
        .clr_en     (ll_valid && ll_ready),
        .clr_addr   (ll_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .issue_addr (issue_addr),
        .rs_busy    (rs_busy),
        .issue_busy (issue_busy)
    );

    // Busy bits may still be set during the reset cycle; hide them.
    assign rs_hazard    = !rst && rs_busy;
    assign issue_hazard = !rst && issue_busy;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural model of the write-back
// rules.
module tb_regfile_wb_ctrl;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_addr;
    logic [31:0] ll_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        issue_hazard;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs_hazard;
    logic        dest_en;
    logic [4:0]  dest_addr;
    logic [31:0] dest_data;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_wb_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_addr      (ex_addr),
        .ex_data      (ex_data),
        .ll_valid     (ll_valid),
        .ll_ready     (ll_ready),
        .ll_addr      (ll_addr),
        .ll_data      (ll_data),
        .issue_en     (issue_en),
        .issue_addr   (issue_addr),
        .issue_hazard (issue_hazard),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs_hazard    (rs_hazard),
        .dest_en      (dest_en),
        .dest_addr    (dest_addr),
        .dest_data    (dest_data)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic exr, input logic llr,
                           input logic den, input logic [4:0] dadr,
                           input logic [31:0] ddat, input logic rsh, input logic ish);
        chk({name, ".ex_ready"}, 32'(ex_ready), 32'(exr));
        chk({name, ".ll_ready"}, 32'(ll_ready), 32'(llr));
        chk({name, ".dest_en"}, 32'(dest_en), 32'(den));
        chk({name, ".dest_addr"}, 32'(dest_addr), 32'(dadr));
        chk({name, ".dest_data"}, dest_data, ddat);
        chk({name, ".rs_hazard"}, 32'(rs_hazard), 32'(rsh));
        chk({name, ".issue_hazard"}, 32'(issue_hazard), 32'(ish));
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at
    // the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit [31:0] m_busy;
    int        m_starve;

    initial begin
        m_busy   = '0;
        m_starve = 0;
    end

    always @(negedge clk) begin
        bit          ex_act, ll_act, ll_wins, guard_on;
        bit          e_exr, e_llr, e_den, e_rsh, e_ish;
        logic [4:0]  e_adr;
        logic [31:0] e_dat;
`ifdef WB_STARVE_GUARD_EN
        guard_on = 1'b1;
`else
        guard_on = 1'b0;
`endif
        ex_act  = ex_valid && (ex_addr != 0);
        ll_act  = ll_valid && (ll_addr != 0);
        ll_wins = ll_act && (!ex_act || (guard_on && (m_starve >= STARVE_MAX)));
        e_exr = 0; e_llr = 0; e_den = 0; e_adr = 0; e_dat = 0; e_rsh = 0; e_ish = 0;
        if (!rst) begin
            e_exr = ex_valid && !(ex_act && ll_wins);
            e_llr = ll_valid && (!ll_act || ll_wins);
            if (ll_wins) begin
                e_den = 1; e_adr = ll_addr; e_dat = ll_data;
            end else if (ex_act) begin
                e_den = 1; e_adr = ex_addr; e_dat = ex_data;
            end
            e_rsh = m_busy[rs1_addr] || m_busy[rs2_addr];
            e_ish = m_busy[issue_addr];
            if (ex_valid && e_exr && ex_addr != 0)
                assert (!m_busy[ex_addr])
                    else $error("protocol violation: execute write to busy x%0d", ex_addr);
        end
        chk("mdl.ex_ready", 32'(ex_ready), 32'(e_exr));
        chk("mdl.ll_ready", 32'(ll_ready), 32'(e_llr));
        chk("mdl.dest_en", 32'(dest_en), 32'(e_den));
        chk("mdl.dest_addr", 32'(dest_addr), 32'(e_adr));
        chk("mdl.dest_data", dest_data, e_dat);
        chk("mdl.rs_hazard", 32'(rs_hazard), 32'(e_rsh));
        chk("mdl.issue_hazard", 32'(issue_hazard), 32'(e_ish));
        // next state, taking effect at the coming rising edge
        if (rst) begin
            m_busy   = '0;
            m_starve = 0;
        end else begin
            if (ll_valid && e_llr && ll_addr != 0) m_busy[ll_addr] = 1'b0;
            if (issue_en && issue_addr != 0)       m_busy[issue_addr] = 1'b1;
            if (ll_valid && !e_llr) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else                    m_starve = 0;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bit exp_ll;
        rst = 1'b1;
        ex_valid = 0; ex_addr = 0; ex_data = 0;
        ll_valid = 0; ll_addr = 0; ll_data = 0;
        issue_en = 0; issue_addr = 0; rs1_addr = 0; rs2_addr = 0;

        // reset, two cycles; second one with an execute request pending
        @(negedge clk);
        chk_all("rst1", 0, 0, 0, 5'd0, 32'h0, 0, 0);
        step();
        ex_valid = 1; ex_addr = 5; ex_data = 32'hDEADBEEF;
        @(negedge clk);
        chk_all("rst2", 0, 0, 0, 5'd0, 32'h0, 0, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_all("ex_wr", 1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);

        // issue x7, RAW/WAW hazard, commit clears it next cycle
        step();
        ex_valid = 0; ex_addr = 0; ex_data = 0;
        issue_en = 1; issue_addr = 7; rs1_addr = 7;
        @(negedge clk);
        chk_all("iss_c0", 0, 0, 0, 5'd0, 32'h0, 0, 0);
        step();
        issue_en = 0;
        @(negedge clk);
        chk_all("iss_c1", 0, 0, 0, 5'd0, 32'h0, 1, 1);
        step();
        @(negedge clk);
        chk_all("iss_c2", 0, 0, 0, 5'd0, 32'h0, 1, 1);
        step();
        ll_valid = 1; ll_addr = 7; ll_data = 32'h1234;
        @(negedge clk);
        chk_all("iss_c3", 0, 1, 1, 5'd7, 32'h1234, 1, 1);
        step();
        ll_valid = 0; ll_addr = 0; ll_data = 0;
        @(negedge clk);
        chk_all("iss_c4", 0, 0, 0, 5'd0, 32'h0, 0, 0);

        // contention: execute streams x1.., long-latency x9 waits
        step();
        rs1_addr = 0; issue_addr = 0;
        ex_valid = 1; ex_addr = 1; ex_data = 32'h100;
        ll_valid = 1; ll_addr = 9; ll_data = 32'h99;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
`ifdef WB_STARVE_GUARD_EN
            if (i == 5) begin
                chk("cont.ll_grant", 32'(ll_ready), 32'd1);
                chk("cont.ex_held", 32'(ex_ready), 32'd0);
                chk("cont.dest_addr", 32'(dest_addr), 32'd9);
            end else begin
                chk("cont.ll_wait", 32'(ll_ready), 32'd0);
                chk("cont.ex_go", 32'(ex_ready), 32'd1);
            end
`else
            chk("cont.ll_wait", 32'(ll_ready), 32'd0);
            chk("cont.ex_go", 32'(ex_ready), 32'd1);
`endif
            step();
`ifdef WB_STARVE_GUARD_EN
            if (i == 5) begin
                ll_valid = 0; ll_addr = 0; ll_data = 0;
                break;
            end
`endif
            ex_addr = ex_addr + 5'd1;
            ex_data = ex_data + 32'h100;
        end
        ex_valid = 0; ex_addr = 0; ex_data = 0;
`ifndef WB_STARVE_GUARD_EN
        @(negedge clk);
        chk_all("cont.drain", 0, 1, 1, 5'd9, 32'h99, 0, 0);
        step();
        ll_valid = 0; ll_addr = 0; ll_data = 0;
`endif

        // x0 bypass
        ex_valid = 1; ex_addr = 0; ex_data = 32'hAAAA;
        ll_valid = 1; ll_addr = 3; ll_data = 32'h3333;
        @(negedge clk);
        chk_all("x0_both", 1, 1, 1, 5'd3, 32'h3333, 0, 0);
        step();
        ll_valid = 0; ll_addr = 0; ll_data = 0;
        @(negedge clk);
        chk_all("x0_ex", 1, 0, 0, 5'd0, 32'h0, 0, 0);
        step();
        ex_valid = 0; ex_data = 0;

        // same-cycle set and clear on x4
        issue_en = 1; issue_addr = 4; rs2_addr = 4;
        @(negedge clk);
        chk_all("sc_issue", 0, 0, 0, 5'd0, 32'h0, 0, 0);
        step();
        ll_valid = 1; ll_addr = 4; ll_data = 32'h44;
        @(negedge clk);
        chk_all("sc_both", 0, 1, 1, 5'd4, 32'h44, 1, 1);
        step();
        issue_en = 0; issue_addr = 0;
        ll_valid = 0; ll_addr = 0; ll_data = 0;
        @(negedge clk);
        chk("sc_setwins", 32'(rs_hazard), 32'd1);
        step();
        ll_valid = 1; ll_addr = 4; ll_data = 32'h55;
        @(negedge clk);
        chk_all("sc_commit", 0, 1, 1, 5'd4, 32'h55, 1, 0);
        step();
        ll_valid = 0; ll_addr = 0; ll_data = 0;
        @(negedge clk);
        chk("sc_cleared", 32'(rs_hazard), 32'd0);
        step();
        rs2_addr = 0;

        // reset mid-flight: x2/x8 busy, long-latency starved 3 cycles
        issue_en = 1; issue_addr = 2;
        step();
        issue_addr = 8;
        step();
        issue_en = 0; issue_addr = 0; rs1_addr = 2; rs2_addr = 8;
        ex_valid = 1; ex_addr = 10; ex_data = 32'hA0;
        ll_valid = 1; ll_addr = 9; ll_data = 32'h909;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid.busy", 32'(rs_hazard), 32'd1);
            chk("mid.ll_wait", 32'(ll_ready), 32'd0);
            step();
            ex_addr = ex_addr + 5'd1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk_all("mid.rst", 0, 0, 0, 5'd0, 32'h0, 0, 0);
        step();
        rst = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk("post.rs_hazard", 32'(rs_hazard), 32'd0);
`ifdef WB_STARVE_GUARD_EN
            exp_ll = (j == 5);
`else
            exp_ll = 1'b0;
`endif
            chk("post.ll_ready", 32'(ll_ready), 32'(exp_ll));
            step();
            if (j < 5) ex_addr = ex_addr + 5'd1;
        end
        ex_valid = 0; ex_addr = 0; ex_data = 0;
        ll_valid = 0; ll_addr = 0; ll_data = 0;
        rs1_addr = 0; rs2_addr = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
